// File: rtl/sram_sp_req_ctrl.sv
// Request-side controller for a single-port SRAM macro.
// Merges independent valid/ready read and write channels into one macro access per cycle,
// zero-fills the array after reset, and catches the one-cycle-valid macro Q into a
// 2-entry in-order response buffer with backpressure.
module sram_sp_req_ctrl #(
   parameter int unsigned DATA_W        = 80,
   parameter int unsigned DEPTH         = 32,
   parameter int unsigned ADDR_W        = $clog2(DEPTH),
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic              CLK,
   input  logic              RSTB,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              init_done,
   output logic              sram_ceb,
   output logic              sram_web,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_d,
   input  logic [DATA_W-1:0] sram_q
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              init_done_q;
   logic              inflight_q;
   logic [DATA_W-1:0] fifo_mem_q [2];
   logic              fifo_wr_ptr_q;
   logic              fifo_rd_ptr_q;
   logic [1:0]        fifo_cnt_q;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] d_q;

   logic       init_active;
   logic       wr_fire;
   logic       rd_fire;
   logic       push;
   logic       pop;
   logic [2:0] occ;
   logic [2:0] occ_after_pop;

   // The sweep is gated by RSTB so the macro is never enabled while reset is held.
   assign init_active = (state_q == StInit) & RSTB;

   assign init_done  = init_done_q;
   assign resp_valid = (fifo_cnt_q != 2'd0);
   assign resp_data  = fifo_mem_q[fifo_rd_ptr_q];

   // Reads are admitted only if the buffer can absorb every read already committed.
   assign pop           = resp_valid & resp_ready;
   assign occ           = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
   assign occ_after_pop = occ - {2'b00, pop};

   assign wr_ready = init_done_q;
   assign rd_ready = init_done_q & ~wr_valid & (occ_after_pop < 3'd2);
   assign wr_fire  = wr_valid & wr_ready;
   assign rd_fire  = rd_valid & rd_ready;

   // Q is only meaningful the cycle after a read; it is never sampled otherwise.
   assign push = inflight_q;

   // Macro request: init sweep, else write, else read, else idle with a/d held.
   always_comb begin
      sram_ceb = 1'b1;
      sram_web = 1'b1;
      sram_a   = a_q;
      sram_d   = d_q;
      if (init_active) begin
         sram_ceb = 1'b0;
         sram_web = 1'b0;
         sram_a   = cnt_q;
         sram_d   = '0;
      end else if (wr_fire) begin
         sram_ceb = 1'b0;
         sram_web = 1'b0;
         sram_a   = wr_addr;
         sram_d   = wr_data;
      end else if (rd_fire) begin
         sram_ceb = 1'b0;
         sram_a   = rd_addr;
      end
   end

   // Init sweep FSM: one zero write per cycle, then RUN with init_done set.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q     <= INIT_ON_RESET ? StInit : StRun;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            StInit: begin
               cnt_q <= cnt_q + ADDR_W'(1);
               if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                  state_q     <= StRun;
                  init_done_q <= 1'b1;
               end
            end
            default: init_done_q <= 1'b1;
         endcase
      end
   end

   // Remember the last driven address/data so idle cycles do not toggle the macro pins.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         a_q <= '0;
         d_q <= '0;
      end else begin
         a_q <= sram_a;
         d_q <= sram_d;
      end
   end

   // Marks the cycle in which sram_q carries read data.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_fire;
      end
   end

   // Two-entry in-order response buffer; push while full is safe only alongside a pop.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         for (int i = 0; i < 2; i++) begin
            fifo_mem_q[i] <= '0;
         end
         fifo_wr_ptr_q <= 1'b0;
         fifo_rd_ptr_q <= 1'b0;
         fifo_cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= sram_q;
            fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
         end
         if (pop) begin
            fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_sp_req_ctrl.sv
// Bench for sram_sp_req_ctrl: behavioural SRAM macro plus a queue-based reference model
// of memory contents and outstanding reads, driven by directed and random steps.
module tb_sram_sp_req_ctrl;

   localparam int DW = 80;
   localparam int D  = 32;
   localparam int AW = 5;

   logic          CLK = 1'b0;
   logic          RSTB;
   logic          wr_valid, wr_ready, rd_valid, rd_ready;
   logic [AW-1:0] wr_addr, rd_addr, sram_a;
   logic [DW-1:0] wr_data, resp_data, sram_d, sram_q;
   logic          resp_valid, resp_ready, init_done, sram_ceb, sram_web;

   sram_sp_req_ctrl #(
      .DATA_W        (DW),
      .DEPTH         (D),
      .ADDR_W        (AW),
      .INIT_ON_RESET (1'b1)
   ) dut (
      .CLK        (CLK),
      .RSTB       (RSTB),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_addr    (rd_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .init_done  (init_done),
      .sram_ceb   (sram_ceb),
      .sram_web   (sram_web),
      .sram_a     (sram_a),
      .sram_d     (sram_d),
      .sram_q     (sram_q)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] rnd_data();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // Macro: Q registered on reads, garbage on every other cycle. Contents are scrambled
   // while reset is held so only the init sweep can produce zeros afterwards.
   logic [DW-1:0] macro_mem [D];
   always @(posedge CLK) begin
      if (!sram_ceb && sram_web) sram_q <= macro_mem[sram_a];
      else                       sram_q <= rnd_data();
      if (!RSTB) begin
         for (int i = 0; i < D; i++) macro_mem[i] <= rnd_data();
      end else if (!sram_ceb && !sram_web) begin
         macro_mem[sram_a] <= sram_d;
      end
   end

   // Reference model: array contents plus every accepted, not-yet-consumed read.
   typedef struct {
      logic [DW-1:0] data;
      int            avail;
   } resp_t;

   resp_t         exp_q[$];
   logic [DW-1:0] ref_mem [D];
   int            init_left;
   int            cyc;
   int            n_cmp;
   int            n_err;
   logic [AW-1:0] last_a;
   logic [DW-1:0] last_d;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, check mid-cycle, advance the model.
   task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic rr);
      logic          e_done, e_wrdy, e_rdrdy, e_rv, e_ceb, e_web, pop, wfire, rfire;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      resp_t         r;
      wr_valid   = wv;
      wr_addr    = wa;
      wr_data    = wd;
      rd_valid   = rv;
      rd_addr    = ra;
      resp_ready = rr;
      #1;
      e_ceb = 1'b1;
      e_web = 1'b1;
      e_a   = last_a;
      e_d   = last_d;
      e_rv  = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      pop   = e_rv && rr;
      if (init_left > 0) begin
         e_done  = 1'b0;
         e_wrdy  = 1'b0;
         e_rdrdy = 1'b0;
         wfire   = 1'b0;
         rfire   = 1'b0;
         e_ceb   = 1'b0;
         e_web   = 1'b0;
         e_a     = AW'(D - init_left);
         e_d     = '0;
      end else begin
         e_done  = 1'b1;
         e_wrdy  = 1'b1;
         e_rdrdy = !wv && ((exp_q.size() - int'(pop)) < 2);
         wfire   = wv;
         rfire   = rv && e_rdrdy;
         if (wfire) begin
            e_ceb = 1'b0;
            e_web = 1'b0;
            e_a   = wa;
            e_d   = wd;
         end else if (rfire) begin
            e_ceb = 1'b0;
            e_a   = ra;
         end
      end
      chk1("init_done", init_done, e_done);
      chk1("wr_ready", wr_ready, e_wrdy);
      chk1("rd_ready", rd_ready, e_rdrdy);
      chk1("resp_valid", resp_valid, e_rv);
      chk1("sram_ceb", sram_ceb, e_ceb);
      chk1("sram_web", sram_web, e_web);
      chkd("sram_a", DW'(sram_a), DW'(e_a));
      chkd("sram_d", sram_d, e_d);
      if (e_rv) chkd("resp_data", resp_data, exp_q[0].data);
      if (init_left > 0) init_left--;
      last_a = e_a;
      last_d = e_d;
      if (wfire) ref_mem[wa] = wd;
      if (pop) void'(exp_q.pop_front());
      if (rfire) begin
         r.data  = ref_mem[ra];
         r.avail = cyc + 2;
         exp_q.push_back(r);
      end
      cyc++;
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b1);
   endtask

   task automatic rand_step();
      step(($urandom % 4) == 0, AW'($urandom % 8), rnd_data(),
           ($urandom % 3) != 0, AW'($urandom % 8), ($urandom % 4) != 0);
   endtask

   // Asserted at a falling edge; outputs must clear at once, released two cycles later.
   task automatic do_reset();
      wr_valid   = 1'b0;
      rd_valid   = 1'b0;
      resp_ready = 1'b0;
      RSTB       = 1'b0;
      #1;
      chk1("rst_init_done", init_done, 1'b0);
      chk1("rst_wr_ready", wr_ready, 1'b0);
      chk1("rst_rd_ready", rd_ready, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk1("rst_sram_ceb", sram_ceb, 1'b1);
      chk1("rst_sram_web", sram_web, 1'b1);
      @(negedge CLK);
      @(negedge CLK);
      exp_q.delete();
      for (int i = 0; i < D; i++) ref_mem[i] = '0;
      init_left = D;
      RSTB      = 1'b1;
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      cyc        = 0;
      init_left  = D;
      last_a     = '0;
      last_d     = '0;
      RSTB       = 1'b1;
      wr_valid   = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      rd_valid   = 1'b0;
      rd_addr    = '0;
      resp_ready = 1'b0;
      @(negedge CLK);
      do_reset();

      // Init sweep with random requests that must all be held off.
      for (int i = 0; i < D; i++) rand_step();
      step(1'b0, '0, '0, 1'b1, AW'(7), 1'b1);
      idle(3);

      // Write then read-after-write of address 3.
      step(1'b1, AW'(3), DW'(80'h5A5A), 1'b0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1, AW'(3), 1'b1);
      idle(3);

      // Preload 0..7 with their address, then back-to-back reads.
      for (int i = 0; i < 8; i++) step(1'b1, AW'(i), DW'(i), 1'b0, '0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, AW'(i), 1'b1);
      idle(3);

      // Backpressure: only two reads admitted, then drain and re-admit.
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, AW'(i + 2), 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1, AW'(5), 1'b1);
      idle(3);

      // Simultaneous write and read: writes win for three cycles, read goes on the fourth.
      for (int i = 0; i < 3; i++) step(1'b1, AW'(10 + i), rnd_data(), 1'b1, AW'(11), 1'b1);
      step(1'b0, '0, '0, 1'b1, AW'(11), 1'b1);
      idle(3);

      for (int i = 0; i < 400; i++) rand_step();
      idle(4);

      // Reset with one response buffered and one read in flight.
      step(1'b0, '0, '0, 1'b1, AW'(1), 1'b0);
      step(1'b0, '0, '0, 1'b1, AW'(2), 1'b0);
      chk1("pre_rst_resp_valid", resp_valid, 1'b1);
      do_reset();
      for (int i = 0; i < D; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1, AW'(1), 1'b1);
      idle(3);
      for (int i = 0; i < 100; i++) rand_step();
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
